// File: rtl/i2c_slave_regfile.sv
// i2c_slave_regfile: oversampling I2C slave in front of an 8-bit register file,
// with a write-strobe port and a registered local read port.
// Optional build macro: I2C_GLITCH_FILTER_EN adds a FILTER_LEN-cycle stability
// filter on SCL and SDA after the synchroniser.
module i2c_slave_regfile #(
  parameter logic [6:0]  I2C_ADR    = 7'h10,
  parameter int unsigned MEM_DEPTH  = 16,
  parameter int unsigned ADR_W      = 4,
  parameter int unsigned FILTER_LEN = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  output logic             busy,
  output logic             wr_strb,
  output logic [ADR_W-1:0] wr_adr,
  output logic [7:0]       wr_data,
  input  logic [ADR_W-1:0] loc_adr,
  output logic [7:0]       loc_rdata
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_DEV_ADR = 4'd1;
  localparam logic [3:0] S_DEV_ACK = 4'd2;
  localparam logic [3:0] S_REG_ADR = 4'd3;
  localparam logic [3:0] S_REG_ACK = 4'd4;
  localparam logic [3:0] S_WR_DATA = 4'd5;
  localparam logic [3:0] S_WR_ACK  = 4'd6;
  localparam logic [3:0] S_RD_DATA = 4'd7;
  localparam logic [3:0] S_RD_ACK  = 4'd8;

  localparam logic [ADR_W-1:0] PTR_MAX = ADR_W'(MEM_DEPTH - 1);
  localparam logic [8:0]       DEPTH_9 = 9'(MEM_DEPTH);

  logic [1:0]       r_scl_sync;
  logic [1:0]       r_sda_sync;
  logic             w_scl;
  logic             w_sda;
  logic             r_scl_d;
  logic             r_sda_d;
  logic             w_scl_rise;
  logic             w_scl_fall;
  logic             w_start;
  logic             w_stop;

  logic [3:0]       r_state;
  logic [3:0]       r_bitcnt;
  logic [6:0]       r_sr;
  logic [7:0]       r_shift;
  logic [ADR_W-1:0] r_ptr;
  logic             r_rw;
  logic [7:0]       r_mem [MEM_DEPTH];

  logic [3:0]       w_state_nxt;
  logic [3:0]       w_bitcnt_nxt;
  logic [6:0]       w_sr_nxt;
  logic [7:0]       w_shift_nxt;
  logic [ADR_W-1:0] w_ptr_nxt;
  logic             w_rw_nxt;
  logic             w_busy_nxt;
  logic             w_oe_nxt;
  logic             w_strb_nxt;
  logic [ADR_W-1:0] w_wadr_nxt;
  logic [7:0]       w_wdata_nxt;
  logic             w_mem_we;
  logic [7:0]       w_byte;
  logic [ADR_W-1:0] w_ptr_inc;

  // Two-flop synchroniser; bus idles high so reset to 1 to avoid false edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_sync <= 2'b11;
      r_sda_sync <= 2'b11;
    end else begin
      r_scl_sync <= {r_scl_sync[0], scl_i};
      r_sda_sync <= {r_sda_sync[0], sda_i};
    end
  end

`ifdef I2C_GLITCH_FILTER_EN
  localparam int unsigned FCNT_W = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

  logic              r_scl_f;
  logic              r_sda_f;
  logic [FCNT_W-1:0] r_scl_cnt;
  logic [FCNT_W-1:0] r_sda_cnt;

  // Stability filter: output follows input after FILTER_LEN consecutive differing samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_f   <= 1'b1;
      r_sda_f   <= 1'b1;
      r_scl_cnt <= '0;
      r_sda_cnt <= '0;
    end else begin
      if (r_scl_sync[1] == r_scl_f) begin
        r_scl_cnt <= '0;
      end else if (r_scl_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        r_scl_f   <= r_scl_sync[1];
        r_scl_cnt <= '0;
      end else begin
        r_scl_cnt <= r_scl_cnt + FCNT_W'(1);
      end
      if (r_sda_sync[1] == r_sda_f) begin
        r_sda_cnt <= '0;
      end else if (r_sda_cnt == FCNT_W'(FILTER_LEN - 1)) begin
        r_sda_f   <= r_sda_sync[1];
        r_sda_cnt <= '0;
      end else begin
        r_sda_cnt <= r_sda_cnt + FCNT_W'(1);
      end
    end
  end

  assign w_scl = r_scl_f;
  assign w_sda = r_sda_f;
`else
  logic w_unused_filt;
  assign w_unused_filt = ^FILTER_LEN;
  assign w_scl = r_scl_sync[1];
  assign w_sda = r_sda_sync[1];
`endif

  // Delayed copies for edge and line-condition detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_d <= 1'b1;
      r_sda_d <= 1'b1;
    end else begin
      r_scl_d <= w_scl;
      r_sda_d <= w_sda;
    end
  end

  assign w_scl_rise = w_scl & ~r_scl_d;
  assign w_scl_fall = ~w_scl & r_scl_d;
  assign w_start    = w_scl & r_scl_d & r_sda_d & ~w_sda;
  assign w_stop     = w_scl & r_scl_d & ~r_sda_d & w_sda;
  assign w_byte     = {r_sr, w_sda};
  assign w_ptr_inc  = (r_ptr == PTR_MAX) ? '0 : r_ptr + ADR_W'(1);

  // Next-state and next-output logic for the protocol engine.
  always_comb begin
    w_state_nxt  = r_state;
    w_bitcnt_nxt = r_bitcnt;
    w_sr_nxt     = r_sr;
    w_shift_nxt  = r_shift;
    w_ptr_nxt    = r_ptr;
    w_rw_nxt     = r_rw;
    w_busy_nxt   = busy;
    w_oe_nxt     = sda_oe;
    w_strb_nxt   = 1'b0;
    w_wadr_nxt   = wr_adr;
    w_wdata_nxt  = wr_data;
    w_mem_we     = 1'b0;

    if (w_stop) begin
      w_state_nxt = S_IDLE;
      w_oe_nxt    = 1'b0;
      w_busy_nxt  = 1'b0;
    end else if (w_start) begin
      w_state_nxt  = S_DEV_ADR;
      w_bitcnt_nxt = 4'd7;
      w_oe_nxt     = 1'b0;
      w_busy_nxt   = 1'b0;
    end else begin
      case (r_state)
        S_DEV_ADR: begin
          if (w_scl_rise) begin
            w_sr_nxt = w_byte[6:0];
            if (r_bitcnt != 4'd0) begin
              w_bitcnt_nxt = r_bitcnt - 4'd1;
            end else if (w_byte[7:1] == I2C_ADR) begin
              w_rw_nxt    = w_byte[0];
              w_busy_nxt  = 1'b1;
              w_state_nxt = S_DEV_ACK;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_REG_ADR: begin
          if (w_scl_rise) begin
            w_sr_nxt = w_byte[6:0];
            if (r_bitcnt != 4'd0) begin
              w_bitcnt_nxt = r_bitcnt - 4'd1;
            end else if ({1'b0, w_byte} < DEPTH_9) begin
              w_ptr_nxt   = w_byte[ADR_W-1:0];
              w_state_nxt = S_REG_ACK;
            end else begin
              w_state_nxt = S_IDLE;
            end
          end
        end
        S_WR_DATA: begin
          if (w_scl_rise) begin
            w_sr_nxt = w_byte[6:0];
            if (r_bitcnt != 4'd0) begin
              w_bitcnt_nxt = r_bitcnt - 4'd1;
            end else begin
              w_mem_we    = 1'b1;
              w_strb_nxt  = 1'b1;
              w_wadr_nxt  = r_ptr;
              w_wdata_nxt = w_byte;
              w_ptr_nxt   = w_ptr_inc;
              w_state_nxt = S_WR_ACK;
            end
          end
        end
        // ACK phase: first SCL fall pulls SDA low, second fall releases it.
        S_DEV_ACK, S_REG_ACK, S_WR_ACK: begin
          if (w_scl_fall) begin
            if (!sda_oe) begin
              w_oe_nxt = 1'b1;
            end else begin
              w_oe_nxt     = 1'b0;
              w_bitcnt_nxt = 4'd7;
              if (r_state == S_DEV_ACK) begin
                if (r_rw) begin
                  w_shift_nxt = r_mem[r_ptr];
                  w_oe_nxt    = ~r_mem[r_ptr][7];
                  w_state_nxt = S_RD_DATA;
                end else begin
                  w_state_nxt = S_REG_ADR;
                end
              end else begin
                w_state_nxt = S_WR_DATA;
              end
            end
          end
        end
        // bitcnt = 8 marks a reloaded byte whose MSB is not yet on the bus.
        S_RD_DATA: begin
          if (w_scl_fall) begin
            if (r_bitcnt == 4'd8) begin
              w_oe_nxt     = ~r_shift[7];
              w_bitcnt_nxt = 4'd7;
            end else if (r_bitcnt == 4'd0) begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_RD_ACK;
            end else begin
              w_shift_nxt  = {r_shift[6:0], 1'b0};
              w_oe_nxt     = ~r_shift[6];
              w_bitcnt_nxt = r_bitcnt - 4'd1;
            end
          end
        end
        S_RD_ACK: begin
          if (w_scl_rise) begin
            if (!w_sda) begin
              w_ptr_nxt    = w_ptr_inc;
              w_shift_nxt  = r_mem[w_ptr_inc];
              w_bitcnt_nxt = 4'd8;
              w_state_nxt  = S_RD_DATA;
            end else begin
              w_oe_nxt    = 1'b0;
              w_state_nxt = S_IDLE;
            end
          end
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  // Protocol state and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_bitcnt <= 4'd0;
      r_sr     <= '0;
      r_shift  <= '0;
      r_ptr    <= '0;
      r_rw     <= 1'b0;
      busy     <= 1'b0;
      sda_oe   <= 1'b0;
      wr_strb  <= 1'b0;
      wr_adr   <= '0;
      wr_data  <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_bitcnt <= w_bitcnt_nxt;
      r_sr     <= w_sr_nxt;
      r_shift  <= w_shift_nxt;
      r_ptr    <= w_ptr_nxt;
      r_rw     <= w_rw_nxt;
      busy     <= w_busy_nxt;
      sda_oe   <= w_oe_nxt;
      wr_strb  <= w_strb_nxt;
      wr_adr   <= w_wadr_nxt;
      wr_data  <= w_wdata_nxt;
    end
  end

  // Register file write and local read port; a colliding read sees the old value.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < int'(MEM_DEPTH); i++) begin
        r_mem[i] <= 8'h00;
      end
      loc_rdata <= 8'h00;
    end else begin
      if (w_mem_we) begin
        r_mem[w_wadr_nxt] <= w_wdata_nxt;
      end
      loc_rdata <= r_mem[loc_adr];
    end
  end

endmodule
